// File: rtl/lsu_pkg.sv
// Shared constants, size codes and state type for the load/store control unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] LD_UNSIGNED = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } lsu_state_e;

  // Stores only accept the three signed encodings; loads also allow bu/hu.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [1:0] f3_last_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of a byte-assembled load value according to funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = data_i;
    case (funct3_i)
      F3_B:    result_o = {{24{data_i[7]}}, data_i[7:0]};
      F3_BU:   result_o = {24'h0, data_i[7:0]};
      F3_H:    result_o = {{16{data_i[15]}}, data_i[15:0]};
      F3_HU:   result_o = {16'h0, data_i[15:0]};
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: checks requests, issues native or byte-split memory
// beats, reassembles misaligned loads and returns a single response pulse.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_store_size,
  output logic [1:0]  mem_load_size,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        misal_q;
  logic        err_q;
  logic [1:0]  beat_q;
  logic [1:0]  last_q;
  logic [31:0] asm_q;
  logic [31:0] rdata_q;

  logic [31:0] asm_d;
  logic [31:0] ext_d;
  logic [1:0]  req_last;
  logic [32:0] req_end;
  logic        req_err;
  logic        req_aligned;

  // End address is formed in 33 bits so a request near 2^32 cannot wrap in range.
  always_comb begin
    req_last    = f3_last_idx(req_funct3);
    req_end     = {1'b0, req_addr} + {31'h0, req_last};
    req_err     = !f3_legal(req_we, req_funct3) || (req_end >= 33'(MEM_BYTES));
    req_aligned = (req_last == 2'd0) ||
                  (req_last == 2'd1 && !req_addr[0]) ||
                  (req_last == 2'd3 && req_addr[1:0] == 2'b00);
  end

  always_comb begin
    asm_d = asm_q;
    asm_d[{beat_q, 3'b000} +: 8] = mem_rdata[7:0];
  end

  lsu_load_extend u_extend (
    .data_i   (asm_d),
    .funct3_i (f3_q),
    .result_o (ext_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      misal_q <= 1'b0;
      err_q   <= 1'b0;
      beat_q  <= 2'd0;
      last_q  <= 2'd0;
      asm_q   <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            misal_q <= !req_aligned;
            err_q   <= req_err;
            beat_q  <= 2'd0;
            last_q  <= req_last;
            asm_q   <= 32'h0;
            rdata_q <= 32'h0;
            state_q <= req_err ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!misal_q) begin
            if (!we_q) rdata_q <= mem_rdata;
            state_q <= S_RESP;
          end else begin
            if (!we_q) asm_q <= asm_d;
            if (beat_q == last_q) begin
              if (!we_q) rdata_q <= ext_d;
              state_q <= S_RESP;
            end else begin
              beat_q <= beat_q + 2'd1;
            end
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;

  // Memory port is driven only from registered state, and stays quiet outside ACCESS.
  always_comb begin
    mem_wr_en      = 1'b0;
    mem_addr       = 32'h0;
    mem_wdata      = 32'h0;
    mem_store_size = SZ_BYTE;
    mem_load_size  = SZ_BYTE;
    mem_funct3     = 3'b000;
    if (state_q == S_ACCESS) begin
      mem_wr_en = we_q;
      if (!misal_q) begin
        mem_addr       = addr_q;
        mem_wdata      = wdata_q;
        mem_store_size = f3_q[1:0];
        mem_load_size  = f3_q[2] ? LD_UNSIGNED : f3_q[1:0];
        mem_funct3     = f3_q;
      end else begin
        mem_addr       = addr_q + {30'h0, beat_q};
        mem_wdata      = wdata_q >> {beat_q, 3'b000};
        mem_store_size = SZ_BYTE;
        mem_load_size  = we_q ? SZ_BYTE : LD_UNSIGNED;
        mem_funct3     = we_q ? F3_B : F3_BU;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a behavioural byte-addressed data memory.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_store_size;
  logic [1:0]  mem_load_size;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.MEM_BYTES(128)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err),
    .resp_rdata     (resp_rdata),
    .mem_wr_en      (mem_wr_en),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_store_size (mem_store_size),
    .mem_load_size  (mem_load_size),
    .mem_funct3     (mem_funct3),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on rising edge.
  logic [7:0]  mem [0:127];
  logic        memLoad;
  logic [31:0] initWord;
  logic [7:0]  rb0, rb1, rb2, rb3;

  always @(posedge clk) begin
    if (memLoad) begin
      for (int k = 0; k < 32; k++) begin
        initWord = 32'(k) + 32'h8765_4321;
        mem[4*k]   <= initWord[7:0];
        mem[4*k+1] <= initWord[15:8];
        mem[4*k+2] <= initWord[23:16];
        mem[4*k+3] <= initWord[31:24];
      end
    end else if (mem_wr_en) begin
      mem[mem_addr[6:0]] <= mem_wdata[7:0];
      if (mem_store_size != SZ_BYTE) mem[mem_addr[6:0] + 7'd1] <= mem_wdata[15:8];
      if (mem_store_size == SZ_WORD) begin
        mem[mem_addr[6:0] + 7'd2] <= mem_wdata[23:16];
        mem[mem_addr[6:0] + 7'd3] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    rb0 = mem[mem_addr[6:0]];
    rb1 = mem[mem_addr[6:0] + 7'd1];
    rb2 = mem[mem_addr[6:0] + 7'd2];
    rb3 = mem[mem_addr[6:0] + 7'd3];
    case (mem_load_size)
      SZ_BYTE: mem_rdata = {{24{rb0[7]}}, rb0};
      SZ_HALF: mem_rdata = {{16{rb1[7]}}, rb1, rb0};
      SZ_WORD: mem_rdata = {rb3, rb2, rb1, rb0};
      default: mem_rdata = (mem_funct3 == F3_HU) ? {16'h0, rb1, rb0} : {24'h0, rb0};
    endcase
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          beats;
    int          writes;
    int          stamp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accessCycles = 0;
  int   writeCycles = 0;
  int   idleMemActive = 0;
  int   respCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: tracks beats between responses and checks each response against the queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      accessCycles  = 0;
      writeCycles   = 0;
      idleMemActive = 0;
    end else begin
      if (!req_ready && !resp_valid) accessCycles++;
      if (mem_wr_en) writeCycles++;
      if ((req_ready || resp_valid) &&
          (mem_wr_en || mem_addr != 0 || mem_wdata != 0 || mem_store_size != 0 ||
           mem_load_size != 0 || mem_funct3 != 0))
        idleMemActive++;
      if (resp_valid) begin
        respCount++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_resp: got resp_valid=1, expected no response");
        end else begin
          e = sbq.pop_front();
          checkOutput("resp_err", 32'(resp_err), 32'(e.err));
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("latency", 32'(cyc - e.stamp), 32'(e.lat));
          checkOutput("access_beats", 32'(accessCycles), 32'(e.beats));
          checkOutput("write_beats", 32'(writeCycles), 32'(e.writes));
          checkOutput("mem_idle_quiet", 32'(idleMemActive), 32'd0);
        end
        accessCycles  = 0;
        writeCycles   = 0;
        idleMemActive = 0;
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic expErr,
                               input logic [31:0] expRdata, input int expLat,
                               input int expBeats, input int expWrites);
    exp_t e;
    int   guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    e = '{expErr, expRdata, expLat, expBeats, expWrites, cyc};
    sbq.push_back(e);
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFF0;
    req_wdata  = 32'h1357_9BDF;
    guard = 0;
    while (sbq.size() != 0 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL resp_timeout: got no response in 30 cycles, expected one at addr 0x%08h", addr);
      sbq.delete();
    end
  endtask

  initial begin
    int savedResp;
    reset      = 1'b1;
    memLoad    = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    reset   = 1'b0;
    memLoad = 1'b0;

    applyStimulus(1'b0, F3_W,  32'h00, 32'h0, 1'b0, 32'h8765_4321, 2, 1, 0);
    applyStimulus(1'b0, F3_B,  32'h03, 32'h0, 1'b0, 32'hFFFF_FF87, 2, 1, 0);
    applyStimulus(1'b0, F3_BU, 32'h03, 32'h0, 1'b0, 32'h0000_0087, 2, 1, 0);
    applyStimulus(1'b0, F3_H,  32'h02, 32'h0, 1'b0, 32'hFFFF_8765, 2, 1, 0);
    applyStimulus(1'b0, F3_HU, 32'h02, 32'h0, 1'b0, 32'h0000_8765, 2, 1, 0);
    applyStimulus(1'b0, F3_W,  32'h01, 32'h0, 1'b0, 32'h2287_6543, 5, 4, 0);
    applyStimulus(1'b0, F3_HU, 32'h05, 32'h0, 1'b0, 32'h0000_6543, 3, 2, 0);
    applyStimulus(1'b1, F3_H,  32'h03, 32'h0000_BEEF, 1'b0, 32'h0, 3, 2, 2);
    applyStimulus(1'b0, F3_W,  32'h00, 32'h0, 1'b0, 32'hEF65_4321, 2, 1, 0);
    applyStimulus(1'b0, F3_W,  32'h04, 32'h0, 1'b0, 32'h8765_43BE, 2, 1, 0);
    applyStimulus(1'b0, F3_H,  32'h03, 32'h0, 1'b0, 32'hFFFF_BEEF, 3, 2, 0);
    applyStimulus(1'b0, F3_HU, 32'h03, 32'h0, 1'b0, 32'h0000_BEEF, 3, 2, 0);
    applyStimulus(1'b0, F3_W,  32'h7E, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    applyStimulus(1'b0, F3_W,  32'h7C, 32'h0, 1'b0, 32'h8765_4340, 2, 1, 0);
    applyStimulus(1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    applyStimulus(1'b1, 3'b100, 32'h00, 32'h1234_5678, 1'b1, 32'h0, 1, 0, 0);
    applyStimulus(1'b0, F3_HU, 32'h7F, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    applyStimulus(1'b1, F3_B,  32'h10, 32'hFFFF_FF5A, 1'b0, 32'h0, 2, 1, 1);
    applyStimulus(1'b0, F3_W,  32'h10, 32'h0, 1'b0, 32'h8765_435A, 2, 1, 0);

    // Misaligned word store interrupted by reset during its second byte beat.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h05;
    req_wdata  = 32'hAABB_CCDD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("beat0_addr", mem_addr, 32'h05);
    checkOutput("beat0_wdata", mem_wdata, 32'hAABB_CCDD);
    @(negedge clk);
    checkOutput("beat1_addr", mem_addr, 32'h06);
    savedResp = respCount;
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_mid_wr_en", 32'(mem_wr_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_no_resp", 32'(respCount - savedResp), 32'd0);
    checkOutput("mem5_written", 32'(mem[5]), 32'hDD);
    checkOutput("mem6_kept", 32'(mem[6]), 32'h65);
    checkOutput("mem7_kept", 32'(mem[7]), 32'h87);
    applyStimulus(1'b0, F3_W, 32'h04, 32'h0, 1'b0, 32'h8765_DDBE, 2, 1, 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by 200000, expected completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
